// File: rtl/store_queue.sv
// Circular store queue: stores wait here until data, base and offset are all
// resolved (at issue or via CDB snoop), then hand off in strict issue order.
module store_queue #(
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  parameter int RB_SIZE   = 16,
  parameter int DEPTH     = 4,
  parameter logic [RB_INDEX-1:0] READY = {RB_INDEX{1'b1}},
  parameter bit ADDR_SUB  = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [RB_INDEX-1:0]         issue_rb,
  input  logic [WORD_SIZE-1:0]        vi,
  input  logic [WORD_SIZE-1:0]        vj,
  input  logic [WORD_SIZE-1:0]        vk,
  input  logic [RB_INDEX-1:0]         qi,
  input  logic [RB_INDEX-1:0]         qj,
  input  logic [RB_INDEX-1:0]         qk,
  input  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data,
  input  logic [RB_SIZE-1:0]          cdb_valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_SIZE-1:0]        out_addr,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic [RB_INDEX-1:0]         out_rb,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OP_W  = RB_INDEX + WORD_SIZE;

  logic                 busy  [DEPTH];
  logic [RB_INDEX-1:0]  rb_q  [DEPTH];
  logic [RB_INDEX-1:0]  qi_q  [DEPTH];
  logic [RB_INDEX-1:0]  qj_q  [DEPTH];
  logic [RB_INDEX-1:0]  qk_q  [DEPTH];
  logic [WORD_SIZE-1:0] vi_q  [DEPTH];
  logic [WORD_SIZE-1:0] vj_q  [DEPTH];
  logic [WORD_SIZE-1:0] vk_q  [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic             do_issue, do_deq;

  // Shared by issue-time bypass and per-cycle snoop: returns {tag, value}.
  function automatic logic [OP_W-1:0] resolve(input logic [RB_INDEX-1:0] q,
                                              input logic [WORD_SIZE-1:0] v);
    logic [OP_W-1:0] r;
    r = {q, v};
    if (q == READY)
      r = {READY, v};
    else if (int'(q) < RB_SIZE && cdb_valid[int'(q)])
      r = {READY, cdb_data[int'(q)*WORD_SIZE +: WORD_SIZE]};
    return r;
  endfunction

  always_comb begin
    issue_ready = (count != CNT_W'(DEPTH));
    out_valid   = busy[head] && (qi_q[head] == READY) &&
                  (qj_q[head] == READY) && (qk_q[head] == READY);
    out_addr    = ADDR_SUB ? (vj_q[head] - vk_q[head]) : (vj_q[head] + vk_q[head]);
    out_data    = vi_q[head];
    out_rb      = rb_q[head];
    do_issue    = issue_valid && issue_ready && !flush;
    do_deq      = out_valid && out_ready && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        rb_q[i] <= '0;
        qi_q[i] <= READY;
        qj_q[i] <= READY;
        qk_q[i] <= READY;
        vi_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) busy[i] <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          {qi_q[i], vi_q[i]} <= resolve(qi_q[i], vi_q[i]);
          {qj_q[i], vj_q[i]} <= resolve(qj_q[i], vj_q[i]);
          {qk_q[i], vk_q[i]} <= resolve(qk_q[i], vk_q[i]);
        end
      end
      // Tail slot is never busy when an issue is accepted, so no snoop conflict.
      if (do_issue) begin
        busy[tail] <= 1'b1;
        rb_q[tail] <= issue_rb;
        {qi_q[tail], vi_q[tail]} <= resolve(qi, vi);
        {qj_q[tail], vj_q[tail]} <= resolve(qj, vj);
        {qk_q[tail], vk_q[tail]} <= resolve(qk, vk);
        tail <= tail + PTR_W'(1);
      end
      if (do_deq) begin
        busy[head] <= 1'b0;
        head <= head + PTR_W'(1);
      end
      case ({do_issue, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: issue/forwarding, ordering, wrap, flush and reset.
module tb_store_queue;

  logic          clk = 1'b0;
  logic          reset, flush, issue_valid, issue_ready;
  logic [3:0]    issue_rb, qi, qj, qk, out_rb;
  logic [31:0]   vi, vj, vk, out_addr, out_data;
  logic [511:0]  cdb_data;
  logic [15:0]   cdb_valid;
  logic          out_valid, out_ready;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  store_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rb(issue_rb),
    .vi(vi), .vj(vj), .vk(vk), .qi(qi), .qj(qj), .qk(qk),
    .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_rb(out_rb), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] rb, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [3:0] ti, input logic [3:0] tj,
                           input logic [3:0] tk);
    issue_valid = 1'b1;
    issue_rb = rb; vi = a; vj = b; vk = c; qi = ti; qj = tj; qk = tk;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
    issue_rb = '0; vi = '0; vj = '0; vk = '0; qi = 4'hF; qj = 4'hF; qk = 4'hF;
    cdb_data = '0; cdb_valid = '0;
    #2;
    check("rst_count", count, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_rb", out_rb, 0);
    #10 reset = 1'b0;
    tick();

    // Ready-at-issue store: visible the following cycle, drained the next.
    set_issue(4'd1, 5, 100, 4, 4'hF, 4'hF, 4'hF);
    tick(); issue_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_addr", out_addr, 96);
    check("t1_data", out_data, 5);
    check("t1_rb", out_rb, 1);
    check("t1_count", count, 1);
    tick();
    check("t1_drained", count, 0);
    check("t1_valid_off", out_valid, 0);

    // Base waits on tag 3, broadcast two cycles after issue.
    set_issue(4'd2, 7, 0, 50, 4'hF, 4'd3, 4'hF);
    tick(); issue_valid = 1'b0;
    check("t2_wait0", out_valid, 0);
    check("t2_count", count, 1);
    tick();
    check("t2_wait1", out_valid, 0);
    cdb_valid[3] = 1'b1; cdb_data[3*32 +: 32] = 32'd200;
    #1 check("t2_bcast_cycle", out_valid, 0);
    tick(); cdb_valid = '0;
    check("t2_valid", out_valid, 1);
    check("t2_addr", out_addr, 150);
    check("t2_data", out_data, 7);
    tick();
    check("t2_drained", count, 0);

    // Fill to capacity with output stalled; pointers start at 2 and wrap.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_issue(4'(4 + k), 32'(10 + k), 32'(20 + k), 1, 4'hF, 4'hF, 4'hF);
      tick();
    end
    check("t3_full_count", count, 4);
    check("t3_issue_ready", issue_ready, 0);
    check("t3_stall_valid", out_valid, 1);
    set_issue(4'd9, 99, 99, 99, 4'hF, 4'hF, 4'hF);
    tick(); issue_valid = 1'b0;
    check("t3_full_reject", count, 4);
    check("t3_stall_rb", out_rb, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_drain_rb", out_rb, 64'(4 + k));
      check("t3_drain_data", out_data, 64'(10 + k));
      check("t3_drain_addr", out_addr, 64'(19 + k));
      tick();
    end
    check("t3_empty", count, 0);
    check("t3_valid_off", out_valid, 0);

    // Unresolved head blocks a ready younger entry.
    set_issue(4'd8, 0, 40, 0, 4'd2, 4'hF, 4'hF);
    tick();
    set_issue(4'd9, 33, 50, 5, 4'hF, 4'hF, 4'hF);
    tick(); issue_valid = 1'b0;
    check("t4_block0", out_valid, 0);
    check("t4_count", count, 2);
    tick();
    check("t4_block1", out_valid, 0);
    cdb_valid[2] = 1'b1; cdb_data[2*32 +: 32] = 32'd77;
    tick(); cdb_valid = '0;
    check("t4_head_rb", out_rb, 8);
    check("t4_head_data", out_data, 77);
    check("t4_head_addr", out_addr, 40);
    tick();
    check("t4_second_rb", out_rb, 9);
    check("t4_second_addr", out_addr, 45);
    tick();
    check("t4_empty", count, 0);

    // Offset captured from CDB in the issue cycle; subtraction wraps.
    set_issue(4'd10, 1, 3, 999, 4'hF, 4'hF, 4'd7);
    cdb_valid[7] = 1'b1; cdb_data[7*32 +: 32] = 32'd8;
    tick(); issue_valid = 1'b0; cdb_valid = '0;
    check("t5_valid", out_valid, 1);
    check("t5_addr", out_addr, 32'hFFFF_FFFB);
    check("t5_rb", out_rb, 10);
    tick();
    check("t5_empty", count, 0);

    // Flush beats a simultaneous issue and dequeue.
    out_ready = 1'b0;
    set_issue(4'd11, 1, 2, 3, 4'hF, 4'hF, 4'hF);
    tick(); tick();
    check("t6_count2", count, 2);
    flush = 1'b1; out_ready = 1'b1;
    tick(); flush = 1'b0; issue_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_valid", out_valid, 0);
    check("t6_flush_ready", issue_ready, 1);

    // Asynchronous reset in the middle of a drain.
    out_ready = 1'b0;
    set_issue(4'd12, 55, 60, 3, 4'hF, 4'hF, 4'hF);
    tick(); tick(); issue_valid = 1'b0;
    check("t6_refill_count", count, 2);
    check("t6_refill_addr", out_addr, 57);
    out_ready = 1'b1;
    tick();
    check("t6_mid_drain", count, 1);
    check("t6_mid_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_areset_valid", out_valid, 0);
    check("t6_areset_count", count, 0);
    check("t6_areset_addr", out_addr, 0);
    check("t6_areset_data", out_data, 0);
    check("t6_areset_rb", out_rb, 0);
    check("t6_areset_ready", issue_ready, 1);
    #1 reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
